// File: rtl/network_queue_arbiter.sv
// Per-channel descriptor FIFOs feeding one registered output stage through a
// round-robin or time-sensitive-first arbiter.
module network_queue_arbiter #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned TAG_W       = 48,
    parameter int unsigned BUFID_W     = 9,
    parameter int unsigned FIFO_AW     = 3,
    parameter int unsigned TYPE_LSB    = 45,
    parameter int unsigned TS_TYPE_MAX = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_CH*TAG_W-1:0]   iv_tsntag,
    input  logic [NUM_CH*BUFID_W-1:0] iv_bufid,
    input  logic [NUM_CH-1:0]         iv_descriptor_wr,
    output logic [NUM_CH-1:0]         ov_descriptor_ack,
    input  logic                      i_sched_mode,
    output logic [TAG_W+BUFID_W-1:0]  ov_descriptor,
    output logic                      o_descriptor_wr,
    input  logic                      i_descriptor_ready,
    output logic [NUM_CH-1:0]         ov_queue_full,
    output logic [NUM_CH-1:0]         ov_queue_empty,
    output logic                      o_overflow_pulse,
    output logic                      o_pkt_cnt_pulse
);
    localparam int unsigned DW    = TAG_W + BUFID_W;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam int unsigned CH_W  = $clog2(NUM_CH);

    logic [DW-1:0]      mem_q     [NUM_CH][DEPTH];
    logic [FIFO_AW-1:0] wptr_q    [NUM_CH];
    logic [FIFO_AW-1:0] wptr_d    [NUM_CH];
    logic [FIFO_AW-1:0] rptr_q    [NUM_CH];
    logic [FIFO_AW-1:0] rptr_d    [NUM_CH];
    logic [CNT_W-1:0]   cnt_q     [NUM_CH];
    logic [CNT_W-1:0]   cnt_d     [NUM_CH];
    logic [DW-1:0]      head_desc [NUM_CH];
    logic [DW-1:0]      in_desc   [NUM_CH];
    logic [2:0]         head_type [NUM_CH];

    logic [NUM_CH-1:0]  full_q, full_d, empty_q, empty_d, ack_q, ack_d;
    logic [NUM_CH-1:0]  push, pop, ts_head, cand;
    logic [CH_W-1:0]    rr_q, rr_d, grant;
    logic [DW-1:0]      out_desc_q, out_desc_d;
    logic               out_wr_q, out_wr_d, ovf_q, ovf_d, pkt_q, pkt_d;
    logic               found, load;
    int unsigned        arb_idx;

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            in_desc[k]   = {iv_tsntag[k*TAG_W +: TAG_W], iv_bufid[k*BUFID_W +: BUFID_W]};
            head_desc[k] = mem_q[k][rptr_q[k]];
            head_type[k] = head_desc[k][BUFID_W+TYPE_LSB +: 3];
            ts_head[k]   = !empty_q[k] && (head_type[k] <= 3'(TS_TYPE_MAX));
        end
        // Time-sensitive heads narrow the candidate set; RR then runs inside it.
        cand = (i_sched_mode && (|ts_head)) ? ts_head : ~empty_q;

        found   = 1'b0;
        grant   = '0;
        arb_idx = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            arb_idx = i + 32'(rr_q);
            if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
            if (!found && cand[CH_W'(arb_idx)]) begin
                found = 1'b1;
                grant = CH_W'(arb_idx);
            end
        end

        load       = !out_wr_q || i_descriptor_ready;
        out_wr_d   = out_wr_q;
        out_desc_d = out_desc_q;
        rr_d       = rr_q;
        if (load) begin
            out_wr_d = found;
            if (found) begin
                out_desc_d = head_desc[grant];
                rr_d       = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
            end
        end
        pkt_d = out_wr_q && i_descriptor_ready;

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        ovf_d = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            pop[k]    = load && found && (grant == CH_W'(k));
            push[k]   = iv_descriptor_wr[k] && !ack_q[k] && (!full_q[k] || pop[k]);
            ovf_d     = ovf_d | (iv_descriptor_wr[k] && !ack_q[k] && full_q[k] && !pop[k]);
            ack_d[k]  = push[k];
            wptr_d[k] = wptr_q[k] + FIFO_AW'(push[k]);
            rptr_d[k] = rptr_q[k] + FIFO_AW'(pop[k]);
            cnt_d[k]  = cnt_q[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
            full_d[k]  = (cnt_d[k] == CNT_W'(DEPTH));
            empty_d[k] = (cnt_d[k] == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
            full_q     <= '0;
            empty_q    <= '1;
            ack_q      <= '0;
            rr_q       <= '0;
            out_wr_q   <= 1'b0;
            out_desc_q <= '0;
            ovf_q      <= 1'b0;
            pkt_q      <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
            full_q     <= full_d;
            empty_q    <= empty_d;
            ack_q      <= ack_d;
            rr_q       <= rr_d;
            out_wr_q   <= out_wr_d;
            out_desc_q <= out_desc_d;
            ovf_q      <= ovf_d;
            pkt_q      <= pkt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (push[k]) mem_q[k][wptr_q[k]] <= in_desc[k];
        end
    end

    assign ov_descriptor_ack = ack_q;
    assign ov_descriptor     = out_desc_q;
    assign o_descriptor_wr   = out_wr_q;
    assign ov_queue_full     = full_q;
    assign ov_queue_empty    = empty_q;
    assign o_overflow_pulse  = ovf_q;
    assign o_pkt_cnt_pulse   = pkt_q;
endmodule
